// File: rtl/qr_out_collector.sv
// qr_out_collector: captures one DIM x DIM frame of streamed Q/R beats from
// the QR CORDIC core into registers, flags completion, a non-upper-triangular
// R and dropped beats, and serves 1-cycle-latency random-access readback.
module qr_out_collector #(
  parameter int DIM     = 4,
  parameter int Q_WIDTH = 12,
  parameter int R_WIDTH = 12,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               qr_valid,
  input  logic [Q_WIDTH-1:0] qr_q,
  input  logic [R_WIDTH-1:0] qr_r,
  input  logic               rel,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic               rd_valid,
  output logic [Q_WIDTH-1:0] rd_q,
  output logic [R_WIDTH-1:0] rd_r,
  output logic               full,
  output logic               frame_done,
  output logic               tri_err,
  output logic               ovf
);

  localparam int DEPTH = DIM * DIM;
  // Row/col counters only need to reach DIM-1; keep at least one bit.
  localparam int RCW   = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [AW:0]        wcnt_q, wcnt_d;
  logic [RCW-1:0]     row_q, row_d;
  logic [RCW-1:0]     col_q, col_d;
  logic               tri_err_q, tri_err_d;
  logic               ovf_q, ovf_d;
  logic               frame_done_q, frame_done_d;
  logic               rd_valid_q, rd_valid_d;
  logic [Q_WIDTH-1:0] rd_q_q, rd_q_d;
  logic [R_WIDTH-1:0] rd_r_q, rd_r_d;
  logic [Q_WIDTH-1:0] qmem_q [DEPTH];
  logic [Q_WIDTH-1:0] qmem_d [DEPTH];
  logic [R_WIDTH-1:0] rmem_q [DEPTH];
  logic [R_WIDTH-1:0] rmem_d [DEPTH];

  // Next-state: frame capture FSM, counters, flags and storage update.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    row_d        = row_q;
    col_d        = col_q;
    tri_err_d    = tri_err_q;
    ovf_d        = ovf_q;
    frame_done_d = 1'b0;
    qmem_d       = qmem_q;
    rmem_d       = rmem_q;

    case (state_q)
      S_FILL: begin
        // rel is deliberately ignored while filling.
        if (qr_valid) begin
          qmem_d[wcnt_q[AW-1:0]] = qr_q;
          rmem_d[wcnt_q[AW-1:0]] = qr_r;
          if ((row_q > col_q) && (qr_r != '0)) begin
            tri_err_d = 1'b1;
          end
          wcnt_d = wcnt_q + 1'b1;
          if (col_q == RCW'(DIM - 1)) begin
            col_d = '0;
            row_d = (row_q == RCW'(DIM - 1)) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (wcnt_q == (AW + 1)'(DEPTH - 1)) begin
            state_d      = S_FULL;
            frame_done_d = 1'b1;
          end
        end
      end
      S_FULL: begin
        // Storage frozen; a beat here is lost, even if released this edge.
        if (qr_valid) begin
          ovf_d = 1'b1;
        end
        if (rel) begin
          state_d   = S_FILL;
          wcnt_d    = '0;
          row_d     = '0;
          col_d     = '0;
          tri_err_d = 1'b0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Readback: registered read of current (pre-write) contents; data holds when idle.
  always_comb begin
    rd_valid_d = rd_en;
    rd_q_d     = rd_q_q;
    rd_r_d     = rd_r_q;
    if (rd_en) begin
      if (int'(rd_addr) < DEPTH) begin
        rd_q_d = qmem_q[rd_addr];
        rd_r_d = rmem_q[rd_addr];
      end else begin
        rd_q_d = '0;
        rd_r_d = '0;
      end
    end
  end

  // State register with asynchronous reset of all control, output and storage flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FILL;
      wcnt_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      tri_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_q_q       <= '0;
      rd_r_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qmem_q[i] <= '0;
        rmem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      tri_err_q    <= tri_err_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
      rd_valid_q   <= rd_valid_d;
      rd_q_q       <= rd_q_d;
      rd_r_q       <= rd_r_d;
      qmem_q       <= qmem_d;
      rmem_q       <= rmem_d;
    end
  end

  assign full       = (state_q == S_FULL);
  assign frame_done = frame_done_q;
  assign tri_err    = tri_err_q;
  assign ovf        = ovf_q;
  assign rd_valid   = rd_valid_q;
  assign rd_q       = rd_q_q;
  assign rd_r       = rd_r_q;

endmodule

// File: tb/tb_qr_out_collector.sv
// Self-checking bench for qr_out_collector: directed frames plus a random
// phase, compared cycle by cycle against a frame-level reference model.
module tb_qr_out_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        qr_valid = 1'b0;
  logic [11:0] qr_q = '0;
  logic [11:0] qr_r = '0;
  logic        rel = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        rd_valid, full, frame_done, tri_err, ovf;
  logic [11:0] rd_q, rd_r;

  // Second instance built with DIM=3 for the out-of-range read case.
  logic        d3_valid = 1'b0;
  logic [11:0] d3_q_in = '0;
  logic [11:0] d3_r_in = '0;
  logic        d3_rd_en = 1'b0;
  logic [3:0]  d3_rd_addr = '0;
  logic        d3_rd_valid, d3_full, d3_done, d3_tri, d3_ovf;
  logic [11:0] d3_rd_q, d3_rd_r;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: frame contents, next index, and flags.
  logic [11:0] m_q [16];
  logic [11:0] m_r [16];
  int          m_k;
  bit          m_full, m_tri, m_ovf;

  always #5 clk = ~clk;

  qr_out_collector #(.DIM(4), .Q_WIDTH(12), .R_WIDTH(12), .AW(4)) dut (
    .clk(clk), .rst(rst), .qr_valid(qr_valid), .qr_q(qr_q), .qr_r(qr_r),
    .rel(rel), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_q(rd_q), .rd_r(rd_r), .full(full), .frame_done(frame_done),
    .tri_err(tri_err), .ovf(ovf)
  );

  qr_out_collector #(.DIM(3), .Q_WIDTH(12), .R_WIDTH(12), .AW(4)) dut3 (
    .clk(clk), .rst(rst), .qr_valid(d3_valid), .qr_q(d3_q_in), .qr_r(d3_r_in),
    .rel(1'b0), .rd_en(d3_rd_en), .rd_addr(d3_rd_addr), .rd_valid(d3_rd_valid),
    .rd_q(d3_rd_q), .rd_r(d3_rd_r), .full(d3_full), .frame_done(d3_done),
    .tri_err(d3_tri), .ovf(d3_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_q[i] = '0;
      m_r[i] = '0;
    end
    m_k = 0; m_full = 0; m_tri = 0; m_ovf = 0;
  endtask

  // One clock: apply inputs, advance model, check every output after the edge.
  task automatic cycle(input bit v, input logic [11:0] q, input logic [11:0] r,
                       input bit rl, input bit re, input logic [3:0] ad);
    logic [11:0] e_rq, e_rr;
    bit          e_done;
    qr_valid = v; qr_q = q; qr_r = r; rel = rl; rd_en = re; rd_addr = ad;
    e_rq = m_q[ad];
    e_rr = m_r[ad];
    e_done = 0;
    @(posedge clk);
    #1;
    if (!m_full) begin
      if (v) begin
        m_q[m_k] = q;
        m_r[m_k] = r;
        if ((m_k / 4) > (m_k % 4) && r != 0) m_tri = 1;
        m_k++;
        if (m_k == 16) begin
          m_full = 1;
          e_done = 1;
        end
      end
    end else begin
      if (v) m_ovf = 1;
      if (rl) begin
        m_full = 0; m_k = 0; m_tri = 0;
      end
    end
    check("full", full, m_full);
    check("frame_done", frame_done, e_done);
    check("tri_err", tri_err, m_tri);
    check("ovf", ovf, m_ovf);
    check("rd_valid", rd_valid, re);
    if (re) begin
      check("rd_q", rd_q, e_rq);
      check("rd_r", rd_r, e_rr);
    end
    $display("cyc v=%0b q=%03h r=%03h rel=%0b rd=%0b@%0d -> full=%0b done=%0b tri=%0b ovf=%0b rq=%03h rr=%03h",
             v, q, r, rl, re, ad, full, frame_done, tri_err, ovf, rd_q, rd_r);
    qr_valid = 0; rel = 0; rd_en = 0;
  endtask

  // Feed beats start_k..15; each beat also reads its own slot (old value).
  task automatic feed_frame(input bit gapped, input bit rnd, input int bad_k, input int start_k);
    logic [11:0] q, r;
    for (int k = start_k; k < 16; k++) begin
      if (gapped && k > start_k) cycle(0, '0, '0, 0, 0, '0);
      q = rnd ? 12'($urandom) : 12'(k + 1);
      if ((k / 4) <= (k % 4)) r = rnd ? 12'($urandom) : 12'(12'h100 + k);
      else                    r = (k == bad_k) ? 12'h005 : 12'h000;
      cycle(1, q, r, 0, 1, 4'(k));
    end
  endtask

  task automatic readback();
    for (int k = 0; k < 16; k++) cycle(0, '0, '0, 0, 1, 4'(k));
    cycle(0, '0, '0, 0, 0, '0);
  endtask

  task automatic release_buf();
    cycle(0, '0, '0, 1, 0, '0);
  endtask

  initial begin
    model_reset();
    #1;
    check("rst_full", full, 0);
    check("rst_done", frame_done, 0);
    check("rst_tri", tri_err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_q", rd_q, 0);
    check("rst_rd_r", rd_r, 0);
    #11 rst = 0;
    @(posedge clk); #1;

    // Frame without gaps, then readback and a same-slot read check.
    feed_frame(0, 0, -1, 0);
    cycle(0, '0, '0, 0, 0, '0);
    readback();
    cycle(0, '0, '0, 0, 1, 4'd15);

    // Gapped frame with random upper-triangular data.
    release_buf();
    feed_frame(1, 1, -1, 0);
    cycle(0, '0, '0, 0, 0, '0);
    readback();

    // Triangle violation at k=4, held until release, then a clean frame.
    release_buf();
    feed_frame(0, 1, 4, 0);
    repeat (3) cycle(0, '0, '0, 0, 0, '0);
    release_buf();
    feed_frame(0, 1, -1, 0);

    // Overflow: beat while full, then release and beat at the same edge.
    cycle(1, 12'hABC, 12'h0, 0, 0, '0);
    cycle(0, '0, '0, 0, 1, 4'd0);
    cycle(1, 12'h777, 12'h1, 1, 0, '0);
    cycle(1, 12'h123, 12'h001, 0, 0, '0);
    cycle(0, '0, '0, 0, 1, 4'd0);
    feed_frame(0, 1, -1, 1);
    readback();

    // Reset after 7 beats of a new frame.
    release_buf();
    for (int k = 0; k < 7; k++) cycle(1, 12'($urandom), 12'h0, 0, 0, '0);
    cycle(0, '0, '0, 0, 1, 4'd3);
    rst = 1;
    #1;
    model_reset();
    check("mid_rst_full", full, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_tri", tri_err, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_rd_q", rd_q, 0);
    check("mid_rst_rd_r", rd_r, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 7; k++) cycle(0, '0, '0, 0, 1, 4'(k));
    feed_frame(0, 1, -1, 0);
    readback();

    // Random phase: random beats, releases, reads and below-diagonal values.
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), 12'($urandom),
            ($urandom_range(0, 5) == 0) ? 12'($urandom) : 12'h000,
            ($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end

    // DIM=3 build: fill 9 entries, read last valid slot and index 12.
    for (int k = 0; k < 9; k++) begin
      d3_valid = 1; d3_q_in = 12'(12'h010 + k); d3_r_in = 12'(12'h020 + k);
      @(posedge clk); #1;
    end
    d3_valid = 0;
    check("d3_full", d3_full, 1);
    d3_rd_en = 1; d3_rd_addr = 4'd8;
    @(posedge clk); #1;
    check("d3_rd8_valid", d3_rd_valid, 1);
    check("d3_rd8_q", d3_rd_q, 12'h018);
    check("d3_rd8_r", d3_rd_r, 12'h028);
    $display("d3 read addr=8 -> valid=%0b q=%03h r=%03h", d3_rd_valid, d3_rd_q, d3_rd_r);
    d3_rd_addr = 4'd12;
    @(posedge clk); #1;
    check("d3_oor_valid", d3_rd_valid, 1);
    check("d3_oor_q", d3_rd_q, 0);
    check("d3_oor_r", d3_rd_r, 0);
    $display("d3 read addr=12 -> valid=%0b q=%03h r=%03h", d3_rd_valid, d3_rd_q, d3_rd_r);
    d3_rd_en = 0;
    @(posedge clk); #1;
    check("d3_rd_valid_fall", d3_rd_valid, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/qr_out_collector.md
# qr_out_collector

Receive-side companion of the QR CORDIC core. It captures the streamed Q and R result elements (`out_valid`/`out_q`/`out_r` beats) of one DIM×DIM decomposition into on-chip registers. It flags frame completion, a non-upper-triangular R, and dropped beats, then serves random-access readback to the downstream consumer (host/testbench or back-substitution stage).

## Interface
- `DIM`, 4: matrix dimension; one frame = DIM*DIM beats.
- `Q_WIDTH`, 12: width of each Q element (matches core `Q_DATA_WIDTH`).
- `R_WIDTH`, 12: width of each R element (matches core `out_r` width).
- `AW`, 4: address width, equal to clog2(DIM*DIM).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `qr_valid`  in  1  beat strobe from the QR core.
- `qr_q`  in  Q_WIDTH  Q element of the current beat.
- `qr_r`  in  R_WIDTH  R element of the current beat.
- `rel`  in  1  consumer releases the full buffer.
- `rd_en`  in  1  read request.
- `rd_addr`  in  AW  element index k = row*DIM + col.
- `rd_valid`  out  1  read data valid.
- `rd_q`  out  Q_WIDTH  stored Q[k].
- `rd_r`  out  R_WIDTH  stored R[k].
- `full`  out  1  buffer holds a complete, unreleased frame.
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `tri_err`  out  1  a below-diagonal R element of the current frame was nonzero.
- `ovf`  out  1  sticky: a beat arrived while full.

## Operation
- Storage: DIM*DIM entries of {Q_WIDTH, R_WIDTH} registers. Beats arrive row-major, with k running 0..DIM*DIM-1.
- Write counter `wcnt` (AW+1 bits), plus row and col counters derived by wrap at DIM.
- States:
  - FILL (reset state).
    - A beat (`qr_valid`=1) writes entry `wcnt` and increments `wcnt`.
    - Gaps between beats are legal; the counter holds while `qr_valid`=0.
    - If the beat's row > col and `qr_r` != 0, set `tri_err`.
    - The beat with `wcnt`=DIM*DIM-1 moves to FULL.
  - FULL. Storage is frozen.
    - A beat is dropped and sets `ovf`.
    - `rel`=1 moves to FILL, clears `wcnt` and `tri_err`, and keeps storage contents.
- `rel` in FILL is ignored.
- `ovf` clears only on `rst`.
- Reads are legal in any state and return current register contents. During FILL, unwritten entries return the previous frame's data (or 0 after reset).
- `rd_addr` >= DIM*DIM: `rd_valid` still asserts and `rd_q`/`rd_r` return 0.
- No arithmetic on data; values are stored bit-exact.

## Timing
- Reset values:
  - `rd_valid`=0, `rd_q`=0, `rd_r`=0.
  - `full`=0, `frame_done`=0, `tri_err`=0, `ovf`=0.
  - All storage 0, `wcnt`=0, state FILL.
- Write: a beat sampled at edge t is readable by a `rd_en` sampled at edge t+1.
- Last beat at edge t: `full`=1 and `frame_done`=1 after edge t, and `frame_done` returns to 0 after edge t+1.
- `tri_err` is registered and visible the cycle after the offending beat.
- Read latency is 1: `rd_en` at edge t gives `rd_valid`/`rd_q`/`rd_r` valid after edge t. `rd_valid` falls after the next edge if `rd_en`=0. Back-to-back reads give one result per cycle.
- `rel` at edge t in FULL: `full`=0 after edge t, and a beat at edge t+1 is accepted as k=0.
- `rel` and `qr_valid` at the same edge in FULL: the beat is dropped, `ovf` is set, and the release is still taken.
- Read and write at the same edge to the same k: the read returns the old value.
- `rst` mid-frame: immediate return to reset values. A partial frame is discarded and the next beat is k=0.

## Test plan
- Frame, no gaps:
  - Stimulus: 16 beats with q=k+1, r=upper-triangular pattern 0x100+k (0 below diagonal).
  - Required: `frame_done` pulses one cycle after beat 15, `full`=1, `tri_err`=0.
  - Readback: reading k=0..15 gives q=1..16 with 1-cycle latency.
- Gapped frame:
  - Stimulus: `qr_valid` toggles 1/0, 16 beats over 31 cycles.
  - Required: same stored contents; `frame_done` one cycle after the 16th beat only.
- Triangle check:
  - Stimulus: beat k=4 (row1,col0) with r=0x005.
  - Required: `tri_err`=1 the next cycle and stays set until `rel`.
  - Follow-up: after `rel` and a clean frame, `tri_err`=0.
- Overflow:
  - Stimulus: a 17th beat (q=0xABC) while full; then `rel` and a new beat at the same edge.
  - Required: `ovf`=1; entry 0 unchanged; after the release `wcnt`=0, and the next beat lands at k=0.
- Reset mid-frame:
  - Stimulus: `rst` pulse after 7 beats.
  - Required: all outputs 0 and reads return 0.
  - Follow-up: a subsequent 16-beat frame completes normally.
- Out-of-range read:
  - Stimulus: `rd_addr`=15 then a parameterised DIM=3 build with `rd_addr`=12.
  - Required: the DIM=3 read gives `rd_valid`=1 with q=r=0.
